dvi_tmds_encoder: RTL and testbench



---
 rtl/dvi_tmds_encoder_if.sv | 14 +
 rtl/dvi_tmds_encoder.sv | 239 +++++++++++++++++++++++
 tb/tb_dvi_tmds_encoder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dvi_tmds_encoder_if.sv
`timescale 1ns/1ps
// Parallel video bus from the timing/pattern generator into the TMDS transmitter:
// three 8-bit colour components plus the sync and data-enable qualifiers.
interface dvi_tmds_encoder_if;
    logic [7:0] blue_din;
    logic [7:0] green_din;
    logic [7:0] red_din;
    logic       hsync;
    logic       vsync;
    logic       de;

    modport master (output blue_din, green_din, red_din, hsync, vsync, de);
    modport slave  (input  blue_din, green_din, red_din, hsync, vsync, de);
endinterface

// File: rtl/dvi_tmds_encoder.sv
`timescale 1ns/1ps
// TMDS transmitter: three 8b/10b TMDS encoders (blue/green/red) and a constant clock
// lane, each serialized 10:1 LSB first by a DDR shift stage running on pixelclk5x.
module dvi_tmds_encoder (
    input  logic               pixelclk,
    input  logic               pixelclk5x,
    input  logic               rst_n,
    dvi_tmds_encoder_if.slave  vid,
    output logic               tmds_clk_p,
    output logic               tmds_clk_n,
    output logic [2:0]         tmds_data_p,
    output logic [2:0]         tmds_data_n
);
    localparam int DATA_W = 8;
    localparam int LANES  = 3;
    localparam int SLOTS  = 4;
    localparam logic [9:0] CLK_WORD = 10'b0000011111;

    typedef struct packed {
        logic [9:0] word;
        logic [4:0] cnt;
    } bal_t;

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~use_xnor;
        return q;
    endfunction

    // Running-disparity balance; cnt tracks ones-minus-zeros of the words sent so far.
    function automatic bal_t tmds_balance(input logic [8:0] qm, input logic [3:0] n1,
                                          input logic signed [4:0] cnt);
        bal_t             r;
        logic [3:0]       n0;
        logic signed [4:0] diff;
        logic signed [4:0] nxt;
        n0   = 4'd8 - n1;
        diff = $signed({1'b0, n1}) - $signed({1'b0, n0});
        if ((cnt == 5'sd0) || (n1 == n0)) begin
            r.word = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            nxt    = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
            r.word = {1'b1, qm[8], ~qm[7:0]};
            nxt    = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            r.word = {1'b0, qm[8], qm[7:0]};
            nxt    = cnt - (qm[8] ? 5'sd0 : 5'sd2) + diff;
        end
        r.cnt = nxt;
        return r;
    endfunction

    function automatic logic [9:0] ctrl_word(input logic c1, input logic c0);
        logic [9:0] w;
        unique case ({c1, c0})
            2'b00:   w = 10'h354;
            2'b01:   w = 10'h0AB;
            2'b10:   w = 10'h154;
            default: w = 10'h2AB;
        endcase
        return w;
    endfunction

    logic [DATA_W-1:0] pix_in [LANES];
    assign pix_in[0] = vid.blue_din;
    assign pix_in[1] = vid.green_din;
    assign pix_in[2] = vid.red_din;

    logic [DATA_W-1:0] din_p1_d [LANES];
    logic [DATA_W-1:0] din_p1_q [LANES];
    logic              vld_p1_d, vld_p1_q;
    logic              hs_p1_d, hs_p1_q;
    logic              vs_p1_d, vs_p1_q;

    logic [8:0]        qm_p2_d [LANES];
    logic [8:0]        qm_p2_q [LANES];
    logic [3:0]        n1_p2_d [LANES];
    logic [3:0]        n1_p2_q [LANES];
    logic              vld_p2_d, vld_p2_q;
    logic              hs_p2_d, hs_p2_q;
    logic              vs_p2_d, vs_p2_q;

    logic [9:0]        word_p3_d [LANES];
    logic [9:0]        word_p3_q [LANES];
    logic signed [4:0] cnt_p3_d [LANES];
    logic signed [4:0] cnt_p3_q [LANES];

    logic              tog_d, tog_q;

    always_comb begin
        bal_t       bal;
        logic [8:0] qm;
        bal = '0;
        qm  = '0;
        // stage 1: capture the pixel bus
        vld_p1_d = vid.de;
        hs_p1_d  = vid.hsync;
        vs_p1_d  = vid.vsync;
        // stage 2: transition-minimised q_m and its ones count
        vld_p2_d = vld_p1_q;
        hs_p2_d  = hs_p1_q;
        vs_p2_d  = vs_p1_q;
        tog_d    = ~tog_q;
        for (int l = 0; l < LANES; l++) begin
            din_p1_d[l] = pix_in[l];
            qm          = tmds_qm(din_p1_q[l]);
            qm_p2_d[l]  = qm;
            n1_p2_d[l]  = ones8(qm[7:0]);
            // stage 3: DC-balanced word or control token
            if (vld_p2_q) begin
                bal          = tmds_balance(qm_p2_q[l], n1_p2_q[l], cnt_p3_q[l]);
                word_p3_d[l] = bal.word;
                cnt_p3_d[l]  = $signed(bal.cnt);
            end else begin
                word_p3_d[l] = (l == 0) ? ctrl_word(vs_p2_q, hs_p2_q) : ctrl_word(1'b0, 1'b0);
                cnt_p3_d[l]  = 5'sd0;
            end
        end
    end

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            hs_p1_q  <= 1'b0;
            vs_p1_q  <= 1'b0;
            vld_p2_q <= 1'b0;
            hs_p2_q  <= 1'b0;
            vs_p2_q  <= 1'b0;
            tog_q    <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                din_p1_q[l]  <= '0;
                qm_p2_q[l]   <= '0;
                n1_p2_q[l]   <= '0;
                word_p3_q[l] <= '0;
                cnt_p3_q[l]  <= '0;
            end
        end else begin
            vld_p1_q <= vld_p1_d;
            hs_p1_q  <= hs_p1_d;
            vs_p1_q  <= vs_p1_d;
            vld_p2_q <= vld_p2_d;
            hs_p2_q  <= hs_p2_d;
            vs_p2_q  <= vs_p2_d;
            tog_q    <= tog_d;
            for (int l = 0; l < LANES; l++) begin
                din_p1_q[l]  <= din_p1_d[l];
                qm_p2_q[l]   <= qm_p2_d[l];
                n1_p2_q[l]   <= n1_p2_d[l];
                word_p3_q[l] <= word_p3_d[l];
                cnt_p3_q[l]  <= cnt_p3_d[l];
            end
        end
    end

    logic [9:0] ld_word [SLOTS];
    assign ld_word[0] = word_p3_q[0];
    assign ld_word[1] = word_p3_q[1];
    assign ld_word[2] = word_p3_q[2];
    assign ld_word[3] = CLK_WORD;

    logic       tog_s1_d, tog_s1_q;
    logic       tog_s2_d, tog_s2_q;
    logic       locked_d, locked_q;
    logic [2:0] ph_d, ph_q;
    logic       mark, load;
    logic [7:0] sh_d [SLOTS];
    logic [7:0] sh_q [SLOTS];
    logic [1:0] pair_d [SLOTS];
    logic [1:0] pair_q [SLOTS];

    // The pixel-domain toggle reaches tog_s1/tog_s2 two 5x edges after a pixel edge;
    // that fixes the phase so the next load lands exactly on the following pixel edge.
    always_comb begin
        tog_s1_d = tog_q;
        tog_s2_d = tog_s1_q;
        mark     = tog_s1_q ^ tog_s2_q;
        locked_d = locked_q | mark;
        ph_d     = (ph_q == 3'd4) ? 3'd0 : ph_q + 3'd1;
        if (mark) ph_d = 3'd3;
        load     = locked_q && (ph_q == 3'd0);
        for (int s = 0; s < SLOTS; s++) begin
            if (load) begin
                pair_d[s] = ld_word[s][1:0];
                sh_d[s]   = ld_word[s][9:2];
            end else begin
                pair_d[s] = sh_q[s][1:0];
                sh_d[s]   = {2'b00, sh_q[s][7:2]};
            end
        end
    end

    always_ff @(posedge pixelclk5x or negedge rst_n) begin
        if (!rst_n) begin
            tog_s1_q <= 1'b0;
            tog_s2_q <= 1'b0;
            locked_q <= 1'b0;
            ph_q     <= 3'd0;
            for (int s = 0; s < SLOTS; s++) begin
                sh_q[s]   <= '0;
                pair_q[s] <= '0;
            end
        end else begin
            tog_s1_q <= tog_s1_d;
            tog_s2_q <= tog_s2_d;
            locked_q <= locked_d;
            ph_q     <= ph_d;
            for (int s = 0; s < SLOTS; s++) begin
                sh_q[s]   <= sh_d[s];
                pair_q[s] <= pair_d[s];
            end
        end
    end

    // DDR output: even bit while pixelclk5x is high, odd bit while it is low.
    logic [SLOTS-1:0] lane_bit;
    always_comb begin
        lane_bit = '0;
        for (int s = 0; s < SLOTS; s++) lane_bit[s] = pixelclk5x ? pair_q[s][0] : pair_q[s][1];
    end

    assign tmds_data_p = lane_bit[2:0];
    assign tmds_data_n = ~lane_bit[2:0];
    assign tmds_clk_p  = lane_bit[3];
    assign tmds_clk_n  = ~lane_bit[3];
endmodule

// File: tb/tb_dvi_tmds_encoder.sv
`timescale 1ns/1ps
// Bench for dvi_tmds_encoder: deserializes every pixel period from the pins and
// compares against hand-computed TMDS words, reset behaviour and a reference decoder.
module tb_dvi_tmds_encoder;
    logic       pixelclk, pixelclk5x, rst_n;
    logic       tmds_clk_p, tmds_clk_n;
    logic [2:0] tmds_data_p, tmds_data_n;

    dvi_tmds_encoder_if vif();

    dvi_tmds_encoder dut (
        .pixelclk    (pixelclk),
        .pixelclk5x  (pixelclk5x),
        .rst_n       (rst_n),
        .vid         (vif),
        .tmds_clk_p  (tmds_clk_p),
        .tmds_clk_n  (tmds_clk_n),
        .tmds_data_p (tmds_data_p),
        .tmds_data_n (tmds_data_n)
    );

    initial begin pixelclk = 1'b0;   forever #20 pixelclk   = ~pixelclk;   end
    initial begin pixelclk5x = 1'b0; forever #4  pixelclk5x = ~pixelclk5x; end

    int total;
    int bad;
    int idx;
    logic [9:0] cap_b [0:1023];
    logic [9:0] cap_g [0:1023];
    logic [9:0] cap_r [0:1023];
    logic [9:0] cap_c [0:1023];
    logic       cap_ok [0:1023];

    typedef struct {
        logic       de, hs, vs;
        logic [7:0] b, g, r;
        logic [9:0] eb, eg, er;
    } vec_t;

    localparam int NV = 19;
    localparam int NR = 48;
    vec_t tbl [NV];
    int   base [NV];

    logic       rde [NR];
    logic       rhs [NR];
    logic       rvs [NR];
    logic [7:0] rpix [NR][3];
    int         rbase [NR];

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        vif.de        = de;
        vif.hsync     = hs;
        vif.vsync     = vs;
        vif.blue_din  = b;
        vif.green_din = g;
        vif.red_din   = r;
    endtask

    function automatic logic [7:0] tmds_dec(input logic [9:0] w);
        logic [7:0] q, d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    function automatic logic [9:0] ctrl_ref(input logic c1, input logic c0);
        logic [9:0] w;
        case ({c1, c0})
            2'b00:   w = 10'h354;
            2'b01:   w = 10'h0AB;
            2'b10:   w = 10'h154;
            default: w = 10'h2AB;
        endcase
        return w;
    endfunction

    // Pin sampler: one 10-bit word per pixel period, bit i at 2+4*i ns after the edge.
    initial begin
        int         k;
        logic [9:0] wb, wg, wr, wc;
        logic       ok;
        idx = 0;
        forever begin
            @(posedge pixelclk);
            idx = idx + 1;
            k   = idx;
            ok  = 1'b1;
            wb = '0; wg = '0; wr = '0; wc = '0;
            for (int b = 0; b < 10; b++) begin
                #(b == 0 ? 2 : 4);
                wb[b] = tmds_data_p[0];
                wg[b] = tmds_data_p[1];
                wr[b] = tmds_data_p[2];
                wc[b] = tmds_clk_p;
                if ((tmds_data_n !== ~tmds_data_p) || (tmds_clk_n !== ~tmds_clk_p)) ok = 1'b0;
            end
            if (k < 1024) begin
                cap_b[k] = wb; cap_g[k] = wg; cap_r[k] = wr; cap_c[k] = wc; cap_ok[k] = ok;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_pins(input string nm);
        chk({nm, "_data_p"}, {7'b0, tmds_data_p}, 10'h000);
        chk({nm, "_data_n"}, {7'b0, tmds_data_n}, 10'h007);
        chk({nm, "_clk_p"},  {9'b0, tmds_clk_p},  10'h000);
        chk({nm, "_clk_n"},  {9'b0, tmds_clk_n},  10'h001);
    endtask

    task automatic post_reset_check(input string nm);
        int e;
        @(posedge pixelclk); #1;
        e = idx;
        repeat (2) @(posedge pixelclk);
        #1;
        chk({nm, "_quiet_b"}, cap_b[e], 10'h000);
        chk({nm, "_quiet_c"}, cap_c[e], 10'h000);
        chk({nm, "_idle_b"},  cap_b[e+1], 10'h354);
        chk({nm, "_idle_g"},  cap_g[e+1], 10'h354);
        chk({nm, "_idle_r"},  cap_r[e+1], 10'h354);
        chk({nm, "_idle_c"},  cap_c[e+1], 10'h01F);
        chk({nm, "_idle_cmpl"}, {9'b0, cap_ok[e+1]}, 10'h001);
    endtask

    initial begin
        int         disp [3];
        logic [9:0] w;
        logic [9:0] exp_ctrl;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        //           de    hs    vs    blue   green  red    exp_b    exp_g    exp_r
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 10'h0AB, 10'h354, 10'h354};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 10'h154, 10'h354, 10'h354};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 10'h2AB, 10'h354, 10'h354};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 10'h200, 10'h200, 10'h200};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 10'h0AB, 10'h354, 10'h354};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h10, 10'h100, 10'h200, 10'h1F0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h55, 10'h3FF, 10'h1FF, 10'h133};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'hAA, 8'hAA, 8'hAA, 10'h233, 10'h233, 10'h233};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h0F, 8'hFE, 10'h100, 10'h105, 10'h2FF};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h0F, 8'hFE, 10'h3FF, 10'h3FA, 10'h000};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 10'h154, 10'h354, 10'h354};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354};

        #50;  chk_reset_pins("rst_a");
        #100; chk_reset_pins("rst_b");
        #51;  rst_n = 1'b1;
        post_reset_check("init");

        for (int i = 0; i < NV; i++) begin
            @(posedge pixelclk); #1;
            drive(tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].b, tbl[i].g, tbl[i].r);
            base[i] = idx + 4;
        end
        @(posedge pixelclk); #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (6) @(posedge pixelclk);
        #1;
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("vec%0d_blue", i),  cap_b[base[i]], tbl[i].eb);
            chk($sformatf("vec%0d_green", i), cap_g[base[i]], tbl[i].eg);
            chk($sformatf("vec%0d_red", i),   cap_r[base[i]], tbl[i].er);
            chk($sformatf("vec%0d_clk", i),   cap_c[base[i]], 10'h01F);
            chk($sformatf("vec%0d_cmpl", i),  {9'b0, cap_ok[base[i]]}, 10'h001);
        end

        // Reset while a data word is on the wire
        @(posedge pixelclk); #1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (4) @(posedge pixelclk);
        #13;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        #1;
        chk_reset_pins("mid_rst");
        #80;
        rst_n = 1'b1;
        post_reset_check("mid");

        for (int i = 0; i < NR; i++) begin
            @(posedge pixelclk); #1;
            rde[i] = (i < 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            rhs[i] = 1'($urandom_range(0, 1));
            rvs[i] = 1'($urandom_range(0, 1));
            for (int l = 0; l < 3; l++) rpix[i][l] = 8'($urandom_range(0, 255));
            drive(rde[i], rhs[i], rvs[i], rpix[i][0], rpix[i][1], rpix[i][2]);
            rbase[i] = idx + 4;
        end
        @(posedge pixelclk); #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (6) @(posedge pixelclk);
        #1;
        disp[0] = 0; disp[1] = 0; disp[2] = 0;
        for (int i = 0; i < NR; i++) begin
            for (int l = 0; l < 3; l++) begin
                w = (l == 0) ? cap_b[rbase[i]] : (l == 1) ? cap_g[rbase[i]] : cap_r[rbase[i]];
                if (rde[i]) begin
                    chk($sformatf("rnd%0d_lane%0d_pix", i, l), {2'b00, tmds_dec(w)}, {2'b00, rpix[i][l]});
                    disp[l] = disp[l] + 2 * $countones(w) - 10;
                    chk($sformatf("rnd%0d_lane%0d_disp_over", i, l),
                        {9'b0, (disp[l] > 10) || (disp[l] < -10)}, 10'h000);
                end else begin
                    exp_ctrl = (l == 0) ? ctrl_ref(rvs[i], rhs[i]) : 10'h354;
                    chk($sformatf("rnd%0d_lane%0d_ctrl", i, l), w, exp_ctrl);
                    disp[l] = 0;
                end
            end
            chk($sformatf("rnd%0d_cmpl", i), {9'b0, cap_ok[rbase[i]]}, 10'h001);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
